// File: rtl/triangle_raster.sv
// Bounding-box triangle rasteriser: scans the clipped box LANES pixels
// per cycle and emits coverage spans over a valid/ready output.
module triangle_raster #(
  parameter int WIDTH   = 1024,
  parameter int HEIGHT  = 720,
  parameter int COORD_W = 10,
  parameter int LANES   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*COORD_W-1:0]   vertex_a,
  input  logic [2*COORD_W-1:0]   vertex_b,
  input  logic [2*COORD_W-1:0]   vertex_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic [LANES-1:0]       out_mask,
  output logic                   out_last,
  output logic                   busy
);

  localparam int BW = COORD_W + 1;
  localparam int EW = 2 * COORD_W + 3;
  localparam logic [BW-1:0] XLIM = BW'(WIDTH - 1);
  localparam logic [BW-1:0] YLIM = BW'(HEIGHT - 1);
  localparam logic [BW-1:0] STEP = BW'(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_FLUSH
  } state_t;

  state_t state, state_n;

  logic [COORD_W-1:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic [BW-1:0] ax, ay, bx, by, qx, qy;
  logic [BW-1:0] xmin_q, xmax_q, ymax_q;
  logic [BW-1:0] cur_x, cur_y;
  logic          area_pos;

  logic [BW-1:0] xmin_s, ymin_s, xmax_r, ymax_r;
  logic [BW-1:0] xmax_s, ymax_s;
  logic signed [EW-1:0] area_s;
  logic          empty_s;

  logic [LANES-1:0] lane_mask;
  logic [BW-1:0]    lx;
  logic signed [EW-1:0] e0, e1, e2;
  logic          row_end, this_last, free;
  logic          latch, setup_en, step, clr_valid;

  function automatic logic [COORD_W-1:0] min3(
    input logic [COORD_W-1:0] p,
    input logic [COORD_W-1:0] q,
    input logic [COORD_W-1:0] r
  );
    logic [COORD_W-1:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic [COORD_W-1:0] max3(
    input logic [COORD_W-1:0] p,
    input logic [COORD_W-1:0] q,
    input logic [COORD_W-1:0] r
  );
    logic [COORD_W-1:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  // (q-p) x (pt-p); positive when pt lies left of p->q
  function automatic logic signed [EW-1:0] edge_fn(
    input logic [BW-1:0] px,
    input logic [BW-1:0] py,
    input logic [BW-1:0] qx_,
    input logic [BW-1:0] qy_,
    input logic [BW-1:0] tx,
    input logic [BW-1:0] ty
  );
    logic signed [EW-1:0] dx, dy, ex, ey;
    dx = $signed(EW'(qx_)) - $signed(EW'(px));
    dy = $signed(EW'(qy_)) - $signed(EW'(py));
    ex = $signed(EW'(tx)) - $signed(EW'(px));
    ey = $signed(EW'(ty)) - $signed(EW'(py));
    return dx * ey - dy * ex;
  endfunction

  assign ax = {1'b0, a_x};
  assign ay = {1'b0, a_y};
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};
  assign qx = {1'b0, c_x};
  assign qy = {1'b0, c_y};

  assign xmin_s = BW'(min3(a_x, b_x, c_x));
  assign ymin_s = BW'(min3(a_y, b_y, c_y));
  assign xmax_r = BW'(max3(a_x, b_x, c_x));
  assign ymax_r = BW'(max3(a_y, b_y, c_y));
  assign xmax_s = (xmax_r > XLIM) ? XLIM : xmax_r;
  assign ymax_s = (ymax_r > YLIM) ? YLIM : ymax_r;
  assign area_s = edge_fn(ax, ay, bx, by, qx, qy);

  assign empty_s = (area_s == '0) ||
                   (xmin_s > xmax_s) ||
                   (ymin_s > ymax_s);

  assign row_end   = (cur_x + STEP) > xmax_q;
  assign this_last = (cur_y == ymax_q) && row_end;
  assign free      = !out_valid || out_ready;

  always_comb begin
    lane_mask = '0;
    lx = '0;
    e0 = '0;
    e1 = '0;
    e2 = '0;
    for (int i = 0; i < LANES; i++) begin
      lx = cur_x + BW'(i);
      e0 = edge_fn(ax, ay, bx, by, lx, cur_y);
      e1 = edge_fn(bx, by, qx, qy, lx, cur_y);
      e2 = edge_fn(qx, qy, ax, ay, lx, cur_y);
      // sign bit clear means >= 0; edges count as inside
      if (lx <= xmax_q) begin
        if (area_pos)
          lane_mask[i] = !e0[EW-1] && !e1[EW-1] &&
                         !e2[EW-1];
        else
          lane_mask[i] = (e0[EW-1] || e0 == '0) &&
                         (e1[EW-1] || e1 == '0) &&
                         (e2[EW-1] || e2 == '0);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n   = state;
    latch     = 1'b0;
    setup_en  = 1'b0;
    step      = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          latch   = 1'b1;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        setup_en = 1'b1;
        state_n  = empty_s ? S_FLUSH : S_SCAN;
      end
      S_SCAN: begin
        if (free) begin
          step = 1'b1;
          if (this_last) state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_valid && out_ready) begin
          clr_valid = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_x <= '0; a_y <= '0;
      b_x <= '0; b_y <= '0;
      c_x <= '0; c_y <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      area_pos <= 1'b0;
      cur_x    <= '0;
      cur_y    <= '0;
      out_valid <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
    end else begin
      if (latch) begin
        {a_x, a_y} <= vertex_a;
        {b_x, b_y} <= vertex_b;
        {c_x, c_y} <= vertex_c;
      end
      if (setup_en) begin
        xmin_q   <= xmin_s;
        xmax_q   <= xmax_s;
        ymax_q   <= ymax_s;
        area_pos <= !area_s[EW-1];
        cur_x    <= xmin_s;
        cur_y    <= ymin_s;
        if (empty_s) begin
          out_valid <= 1'b1;
          out_x    <= xmin_s[COORD_W-1:0];
          out_y    <= ymin_s[COORD_W-1:0];
          out_mask <= '0;
          out_last <= 1'b1;
        end
      end
      if (step) begin
        // blank interior spans are dropped without an output slot
        if (lane_mask != '0 || this_last) begin
          out_valid <= 1'b1;
          out_x    <= cur_x[COORD_W-1:0];
          out_y    <= cur_y[COORD_W-1:0];
          out_mask <= lane_mask;
          out_last <= this_last;
        end else begin
          out_valid <= 1'b0;
        end
        if (row_end) begin
          cur_x <= xmin_q;
          cur_y <= cur_y + BW'(1);
        end else begin
          cur_x <= cur_x + STEP;
        end
      end
      if (clr_valid) out_valid <= 1'b0;
    end
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_triangle_raster.sv
// Scoreboard bench for triangle_raster: directed triangles, expected
// spans queued at issue time and popped by an output monitor.
module tb_triangle_raster;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] m;
    logic       l;
  } span_t;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic out_ready = 1'b1;
  logic rnd = 1'b0;
  logic [19:0] va = '0, vb = '0, vc = '0;
  logic iv [2];
  logic ir [2];
  logic ov [2];
  logic ol [2];
  logic bsy [2];
  logic [9:0] ox [2];
  logic [9:0] oy [2];
  logic [3:0] om [2];

  span_t q0[$];
  span_t q1[$];
  span_t held [2];
  logic  stalled [2];

  int pass_cnt = 0;
  int tot_cnt = 0;

  always #5 clk_in = ~clk_in;

  triangle_raster dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .vertex_a(va), .vertex_b(vb), .vertex_c(vc),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_x(ox[0]), .out_y(oy[0]), .out_mask(om[0]),
    .out_last(ol[0]), .busy(bsy[0])
  );

  triangle_raster #(.WIDTH(1022)) dut_c (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .vertex_a(va), .vertex_b(vb), .vertex_c(vc),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_x(ox[1]), .out_y(oy[1]), .out_mask(om[1]),
    .out_last(ol[1]), .busy(bsy[1])
  );

  task automatic chk(input string name, input logic ok,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [19:0] v(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input int x, input int y,
                      input logic [3:0] m, input logic l);
    span_t s;
    s = '{x: 10'(x), y: 10'(y), m: m, l: l};
    if (d == 0) q0.push_back(s);
    else        q1.push_back(s);
  endtask

  // covered iff x,y >= 0 and 29x + 39y <= 1131 (A=0,0 B=39,0 C=0,29)
  task automatic push_big();
    logic [3:0] m;
    logic l;
    for (int y = 0; y < 30; y++) begin
      for (int cx = 0; cx <= 39; cx += 4) begin
        m = '0;
        for (int i = 0; i < 4; i++)
          if (cx + i <= 39 && 29 * (cx + i) + 39 * y <= 1131)
            m[i] = 1'b1;
        l = (y == 29) && (cx + 4 > 39);
        if (m != 0 || l) push(0, cx, y, m, l);
      end
    end
  endtask

  task automatic push_right(input int d);
    push(d, 0, 0, 4'b1111, 1'b0);
    push(d, 0, 1, 4'b0111, 1'b0);
    push(d, 0, 2, 4'b0011, 1'b0);
    push(d, 0, 3, 4'b0001, 1'b1);
  endtask

  // returns at posedge+1 just after the accepting edge
  task automatic issue(input int d, input logic [19:0] a,
                       input logic [19:0] b, input logic [19:0] c);
    int n;
    n = 0;
    va = a; vb = b; vc = c;
    iv[d] = 1'b1;
    while (!ir[d] && n < 100) begin
      @(posedge clk_in); #1; n++;
    end
    chk("accept", ir[d], 64'(ir[d]), 64'd1);
    @(posedge clk_in); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    while ((bsy[d] || qsize(d) != 0) && n < 3000) begin
      if (ir[d] && bsy[d]) bad = 1'b1;
      @(posedge clk_in); #1; n++;
    end
    chk("done", !bsy[d] && qsize(d) == 0,
        64'(qsize(d)), 64'd0);
    chk("in_ready_low", !bad, 64'(bad), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk_in); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk_in) begin
    span_t got, want;
    if (rst_n_in) begin
      for (int d = 0; d < 2; d++) begin
        got = '{x: ox[d], y: oy[d], m: om[d], l: ol[d]};
        if (stalled[d])
          chk("stable", ov[d] && got == held[d],
              64'(got), 64'(held[d]));
        stalled[d] = ov[d] && !out_ready;
        held[d] = got;
        if (ov[d] && out_ready) begin
          if (qsize(d) == 0) begin
            chk("unexpected_span", 1'b0, 64'(got), 64'd0);
          end else begin
            want = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("span", got == want, 64'(got), 64'(want));
          end
        end
      end
    end else begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end
  end

  initial begin
    iv[0] = 1'b0; iv[1] = 1'b0;
    stalled[0] = 1'b0; stalled[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    #2;
    chk("rst_out_valid", ov[0] == 1'b0, 64'(ov[0]), 64'd0);
    chk("rst_busy", bsy[0] == 1'b0, 64'(bsy[0]), 64'd0);
    chk("rst_out_regs", {ox[0], oy[0], om[0], ol[0]} == '0,
        64'({ox[0], oy[0], om[0], ol[0]}), 64'd0);
    #10 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rst_in_ready", ir[0] == 1'b1, 64'(ir[0]), 64'd1);

    // right triangle, span latency
    push_right(0);
    issue(0, v(0, 0), v(3, 0), v(0, 3));
    @(posedge clk_in); #1;
    chk("lat_cycle1", ov[0] == 1'b0, 64'(ov[0]), 64'd0);
    @(posedge clk_in); #1;
    chk("lat_cycle2", ov[0] == 1'b1, 64'(ov[0]), 64'd1);
    wait_done(0);

    // opposite winding
    push_right(0);
    issue(0, v(0, 0), v(0, 3), v(3, 0));
    wait_done(0);

    // collinear
    push(0, 5, 5, 4'b0000, 1'b1);
    issue(0, v(5, 5), v(10, 10), v(15, 15));
    @(posedge clk_in); #1;
    chk("empty_valid", ov[0] == 1'b1, 64'(ov[0]), 64'd1);
    @(posedge clk_in); #1;
    chk("empty_busy", bsy[0] == 1'b0, 64'(bsy[0]), 64'd0);
    chk("empty_ready", ir[0] == 1'b1, 64'(ir[0]), 64'd1);
    wait_done(0);

    // right-edge clipping on the narrow-screen instance
    push(1, 1020, 0, 4'b0011, 1'b0);
    push(1, 1020, 1, 4'b0010, 1'b0);
    push(1, 1020, 3, 4'b0000, 1'b1);
    issue(1, v(1020, 0), v(1023, 0), v(1023, 3));
    wait_done(1);

    // large triangle, full rate then with random backpressure
    push_big();
    issue(0, v(0, 0), v(39, 0), v(0, 29));
    wait_done(0);
    rnd = 1'b1;
    push_big();
    issue(0, v(0, 0), v(39, 0), v(0, 29));
    wait_done(0);
    rnd = 1'b0;
    @(posedge clk_in); #1;

    // reset mid-scan
    push_big();
    issue(0, v(0, 0), v(39, 0), v(0, 29));
    repeat (8) @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    chk("midrst_valid", ov[0] == 1'b0, 64'(ov[0]), 64'd0);
    chk("midrst_busy", bsy[0] == 1'b0, 64'(bsy[0]), 64'd0);
    q0.delete();
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_ready", ir[0] == 1'b1, 64'(ir[0]), 64'd1);
    push_right(0);
    issue(0, v(0, 0), v(3, 0), v(0, 3));
    wait_done(0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/triangle_raster.md
Name: triangle_raster

Overview:
- Parametrised bounding-box rasteriser. It is the successor of the fixed five-worker pixel-checking colourer.
- Accepts one screen-space triangle per valid/ready handshake and scans its screen-clipped bounding box LANES pixels per cycle.
- Emits horizontal spans with a per-lane coverage mask over a valid/ready output with backpressure. Exactly one last-flagged span is emitted per triangle.
- Sits between the triangle-vertex BRAM reader and the framebuffer write logic.

Parameters:
- WIDTH, 1024, screen width in pixels; x coordinates above WIDTH-1 are clipped.
- HEIGHT, 720, screen height in pixels; y coordinates above HEIGHT-1 are clipped.
- COORD_W, 10, bits per unsigned x or y coordinate.
- LANES, 4, pixels tested per cycle (1..16); equals the span width.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- in_valid  in  1  triangle available.
- in_ready  out  1  block can accept a triangle; high only in IDLE.
- vertex_a  in  2*COORD_W  {x,y} of vertex A, x in the upper half.
- vertex_b  in  2*COORD_W  {x,y} of vertex B.
- vertex_c  in  2*COORD_W  {x,y} of vertex C.
- out_valid  out  1  span valid.
- out_ready  in  1  downstream accepts the span.
- out_x  out  COORD_W  x of lane 0.
- out_y  out  COORD_W  row of the span.
- out_mask  out  LANES  bit i set means pixel (out_x+i, out_y) is covered.
- out_last  out  1  final span of the triangle.
- busy  out  1  high from triangle acceptance until the last span is accepted.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; out_valid, out_last, busy = 0; out_x, out_y, out_mask = 0; in_ready = 1 once released.
  - A reset mid-scan abandons the triangle and emits no last span.
- States: IDLE, SETUP, SCAN, FLUSH.
- IDLE:
  - in_valid & in_ready latches the vertices; go to SETUP; busy = 1.
- SETUP (1 cycle):
  - xmin/ymin = minimum of the vertices.
  - xmax = min(max vertex x, WIDTH-1); ymax = min(max vertex y, HEIGHT-1).
  - area = E_ab(C), a signed value.
  - Empty triangle: area == 0 or xmin > xmax or ymin > ymax. Go to FLUSH with one span {xmin, ymin, mask 0, last 1}.
  - Otherwise set cursor (cx, cy) = (xmin, ymin) and go to SCAN.
- Edge functions: E_pq(px,py) = (qx-px)*(py-p.y) - (qy-p.y)*(px-p.x), signed, 2*COORD_W+3 bits, no overflow. All are computed combinationally for the LANES pixels at the cursor.
- Lane coverage:
  - Lane i is covered iff cx+i <= xmax and all three edges are >=0 when area > 0, or all three are <=0 when area < 0.
  - Edge pixels are inclusive, and the result is independent of winding order.
- SCAN, each cycle the output register is free (out_valid == 0, or out_ready high that cycle):
  - Compute the span mask; this_last = (cy == ymax) && (cx+LANES > xmax).
  - If mask != 0 or this_last, load the output register with {cx, cy, mask, this_last} and assert out_valid the next cycle.
  - All-zero non-last spans are skipped and consume no output cycle.
  - Cursor advance: if cx+LANES > xmax then cx = xmin, cy = cy+1, else cx = cx+LANES.
  - When the output register is not free, the cursor and mask are held.
  - After loading the last span, go to FLUSH.
- FLUSH:
  - Hold out_* stable until out_valid & out_ready; then out_valid = 0, busy = 0, state IDLE.
  - in_ready rises the cycle after that.
- Output stability: out_x, out_y, out_mask and out_last must not change while out_valid & !out_ready.
- Throughput: one span per cycle with out_ready held high.
- Latency: in handshake at cycle 0, first span visible at cycle 2 at the earliest.
- Bounding-box arithmetic uses COORD_W+1 bits so that cx+LANES never wraps.

Test Plan:
- Setup: LANES=4, WIDTH=1024, HEIGHT=720 unless stated.
- Right triangle A=(0,0), B=(3,0), C=(0,3), out_ready=1 -> 4 spans at x=0, y=0..3 with masks 0b1111, 0b0111, 0b0011, 0b0001; last only on y=3; first out_valid at cycle 2.
- Same triangle, vertices given in the opposite winding (A, C, B) -> identical span stream.
- Collinear A=(5,5), B=(10,10), C=(15,15) -> exactly one span {x=5, y=5, mask 0, last 1}; busy drops after its handshake.
- Triangle A=(1020,0), B=(1023,0), C=(1023,3) with x beyond WIDTH-1 clipped (use WIDTH=1022) -> no mask bit set for x>1021; last span at y=3.
- Randomised out_ready (50%) over a 40x30 triangle -> span contents and order match an out_ready=1 run; out_* stable while stalled; in_ready low until the final handshake.
- rst_n_in pulsed low mid-SCAN -> out_valid and busy drop immediately (asynchronously); in_ready=1 after release; a new triangle then rasterises correctly.
